// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the regfile write-port scheduler: default widths,
// arbiter state encodings and write-port constants.
package regfile_wb_sched_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;

    // Arbiter priority state: who wins when both requesters are valid.
    typedef enum logic {
        PRI_WB = 1'b0,
        PRI_LU = 1'b1
    } sched_state_e;

    localparam logic        WE_ON     = 1'b1;
    localparam logic        WE_OFF    = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// Busy scoreboard: one bit per GPR marking an outstanding long-latency result.
// Issue sets a bit, an LU writeback grant clears it; set wins on a same-cycle
// collision and $0 is never marked busy.
module regfile_scoreboard
    import regfile_wb_sched_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_i,
    input  logic [ADDR_W-1:0]   set_addr_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   clr_addr_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Decode set/clear into masks and merge; set applied after clear so it wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_i && (clr_addr_i == ADDR_W'(i))) busy_d[i] = 1'b0;
            if (set_i && (set_addr_i == ADDR_W'(i))) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Regfile write-port scheduler: arbitrates the single GPR write port between
// pipeline writeback (WB) and a long-latency unit (LU), with an age counter
// that forces an LU win after STARVE_LIMIT consecutive lost conflicts.
// Optional build macro SCHED_STATS_EN adds conflict / forced-grant counters.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid_i,
    input  logic [ADDR_W-1:0]   wb_waddr_i,
    input  logic [DATA_W-1:0]   wb_wdata_i,
    output logic                wb_ready_o,
    input  logic                lu_issue_i,
    input  logic [ADDR_W-1:0]   lu_issue_addr_i,
    input  logic                lu_valid_i,
    input  logic [ADDR_W-1:0]   lu_waddr_i,
    input  logic [DATA_W-1:0]   lu_wdata_i,
    output logic                lu_ready_o,
    output logic                rf_we_o,
    output logic [ADDR_W-1:0]   rf_waddr_o,
    output logic [DATA_W-1:0]   rf_wdata_o,
`ifdef SCHED_STATS_EN
    output logic [15:0]         stat_conflicts_o,
    output logic [15:0]         stat_forced_o,
`endif
    output logic [NUM_REGS-1:0] busy_vec_o
);

    localparam logic [3:0] AGE_MAX = 4'(STARVE_LIMIT - 1);

    sched_state_e        state_q, state_d;
    logic [3:0]          age_q, age_d;
    logic                wb_gnt, lu_gnt, conflict;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;

    assign conflict = wb_valid_i && lu_valid_i;

    // Grant, priority FSM next state and starvation age.
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        wb_gnt  = 1'b0;
        lu_gnt  = 1'b0;
        if (!rst) begin
            if (conflict) begin
                lu_gnt = (state_q == PRI_LU);
                wb_gnt = !lu_gnt;
            end else begin
                wb_gnt = wb_valid_i;
                lu_gnt = lu_valid_i;
            end
        end
        if (lu_gnt || !lu_valid_i)
            age_d = 4'd0;
        else if (conflict && wb_gnt && (age_q != AGE_MAX))
            age_d = age_q + 4'd1;
        case (state_q)
            PRI_WB: if (conflict && wb_gnt && (age_q == AGE_MAX)) state_d = PRI_LU;
            PRI_LU: if (lu_gnt || !lu_valid_i) state_d = PRI_WB;
            default: state_d = PRI_WB;
        endcase
    end

    assign wb_ready_o = wb_gnt;
    assign lu_ready_o = lu_gnt;

    assign gnt_addr = lu_gnt ? lu_waddr_i : wb_waddr_i;
    assign gnt_data = lu_gnt ? lu_wdata_i : wb_wdata_i;

    // Write-port staging: writes to $0 are accepted but never reach the file,
    // and the address/data registers only move on a real write.
    always_comb begin
        rf_we_d    = WE_OFF;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if ((wb_gnt || lu_gnt) && (gnt_addr != '0)) begin
            rf_we_d    = WE_ON;
            rf_waddr_d = gnt_addr;
            rf_wdata_d = gnt_data;
        end
    end

    // Arbiter state and registered regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PRI_WB;
            age_q      <= 4'd0;
            rf_we_q    <= WE_OFF;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            age_q      <= age_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (lu_issue_i),
        .set_addr_i (lu_issue_addr_i),
        .clr_i      (lu_gnt),
        .clr_addr_i (lu_waddr_i),
        .busy_vec_o (busy_vec_o)
    );

`ifdef SCHED_STATS_EN
    logic [15:0] stat_conflicts_q, stat_forced_q;

    // Saturating counters: conflict cycles and LU grants forced by starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflicts_q <= '0;
            stat_forced_q    <= '0;
        end else begin
            if (conflict && (stat_conflicts_q != 16'hFFFF))
                stat_conflicts_q <= stat_conflicts_q + 16'd1;
            if (lu_gnt && (state_q == PRI_LU) && (stat_forced_q != 16'hFFFF))
                stat_forced_q <= stat_forced_q + 16'd1;
        end
    end

    assign stat_conflicts_o = stat_conflicts_q;
    assign stat_forced_o    = stat_forced_q;
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, single writes, starvation
// rotation, scoreboard set/clear, $0 handling and (optionally) statistics.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, lu_issue, lu_valid;
    logic [4:0]  wb_waddr, lu_issue_addr, lu_waddr;
    logic [31:0] wb_wdata, lu_wdata;
    logic        wb_ready, lu_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_vec;
`ifdef SCHED_STATS_EN
    logic [15:0] stat_conflicts, stat_forced;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_wb_sched #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_valid_i      (wb_valid),
        .wb_waddr_i      (wb_waddr),
        .wb_wdata_i      (wb_wdata),
        .wb_ready_o      (wb_ready),
        .lu_issue_i      (lu_issue),
        .lu_issue_addr_i (lu_issue_addr),
        .lu_valid_i      (lu_valid),
        .lu_waddr_i      (lu_waddr),
        .lu_wdata_i      (lu_wdata),
        .lu_ready_o      (lu_ready),
        .rf_we_o         (rf_we),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
`ifdef SCHED_STATS_EN
        .stat_conflicts_o(stat_conflicts),
        .stat_forced_o   (stat_forced),
`endif
        .busy_vec_o      (busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; land just after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_0011;
        lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h0000_0022;
        lu_issue = 1'b0; lu_issue_addr = 5'd0;

        // Reset held two cycles with both requesters valid.
        tick(); tick();
        chk("rst_we",    rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_busy",  busy_vec, 0);
        chk("rst_wbrdy", wb_ready, 0);
        chk("rst_lurdy", lu_ready, 0);

        // Release: WB wins the first conflict.
        rst = 1'b0; #1;
        chk("rel_wbrdy", wb_ready, 1);
        chk("rel_lurdy", lu_ready, 0);
        tick();
        wb_valid = 1'b0; lu_valid = 1'b0;
        chk("rel_we",    rf_we, 1);
        chk("rel_waddr", rf_waddr, 3);
        chk("rel_wdata", rf_wdata, 32'h11);

        // Single WB write.
        wb_valid = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF; #1;
        chk("wb_rdy", wb_ready, 1);
        tick();
        wb_valid = 1'b0;
        chk("wb_we",    rf_we, 1);
        chk("wb_waddr", rf_waddr, 5);
        chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        chk("wb_we_off",   rf_we, 0);
        chk("wb_hold_dat", rf_wdata, 32'hDEADBEEF);

        // Scoreboard: issue 9, then complete 9.
        lu_issue = 1'b1; lu_issue_addr = 5'd9;
        tick();
        lu_issue = 1'b0;
        chk("sb_set9", busy_vec, 32'h0000_0200);
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h0000_0099; #1;
        chk("sb_lurdy", lu_ready, 1);
        chk("sb_wbrdy", wb_ready, 0);
        tick();
        lu_valid = 1'b0;
        chk("sb_clr9",  busy_vec, 0);
        chk("lu_we",    rf_we, 1);
        chk("lu_waddr", rf_waddr, 9);
        chk("lu_wdata", rf_wdata, 32'h99);

        // Same-cycle set and clear of 9: set wins.
        lu_issue = 1'b1; lu_issue_addr = 5'd9;
        tick();
        lu_valid = 1'b1; lu_waddr = 5'd9;
        tick();
        lu_issue = 1'b0; lu_valid = 1'b0;
        chk("sb_setwins", busy_vec, 32'h0000_0200);
        lu_valid = 1'b1;
        tick();
        lu_valid = 1'b0;
        chk("sb_clr_again", busy_vec, 0);

        // $0: WB accepted but no write; issue to $0 never marks busy.
        wb_valid = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h77;
        lu_issue = 1'b1; lu_issue_addr = 5'd0; #1;
        chk("z_wbrdy", wb_ready, 1);
        tick();
        wb_valid = 1'b0; lu_issue = 1'b0;
        chk("z_we",   rf_we, 0);
        chk("z_busy", busy_vec, 0);

        // Starvation: 4 WB wins, then forced LU, then back to WB.
        wb_valid = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hA;
        lu_valid = 1'b1; lu_waddr = 5'd2; lu_wdata = 32'hB;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("st_lurdy_c%0d", c), lu_ready, (c % 5) == 4);
            chk($sformatf("st_wbrdy_c%0d", c), wb_ready, (c % 5) != 4);
            tick();
            chk($sformatf("st_waddr_c%0d", c), rf_waddr, ((c % 5) == 4) ? 2 : 1);
        end
        // 12 conflicts: c10, c11 are WB wins (age 2). Two more puts FSM in PRI_LU.
        tick(); tick();
        #1;
        chk("st_prilu", lu_ready, 1);
        // Dropping lu_valid in PRI_LU returns to PRI_WB with age cleared.
        lu_valid = 1'b0; #1;
        chk("drop_wbrdy", wb_ready, 1);
        tick();
        lu_valid = 1'b1; #1;
        chk("drop_back_wb", wb_ready, 1);
        chk("drop_back_lu", lu_ready, 0);

        // Mid-operation reset with a busy bit outstanding.
        lu_issue = 1'b1; lu_issue_addr = 5'd20;
        tick();
        lu_issue = 1'b0;
        chk("mid_busy", busy_vec, 32'h0010_0000);
        rst = 1'b1; #1;
        chk("mid_rdy", {wb_ready, lu_ready}, 0);
        tick();
        chk("mid_busy_clr", busy_vec, 0);
        chk("mid_we", rf_we, 0);
        rst = 1'b0;

        // Six conflict cycles from reset: WB x4, forced LU, WB.
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("s6_lurdy_c%0d", c), lu_ready, c == 4);
            tick();
        end
        wb_valid = 1'b0; lu_valid = 1'b0;
`ifdef SCHED_STATS_EN
        chk("stat_conflicts", stat_conflicts, 6);
        chk("stat_forced",    stat_forced, 1);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
